// File: rtl/field_packer.sv
// Packs four 3-bit fields plus a 2-bit select code into one 16-bit word with a valid/ready handshake.
// Optional parity bit in o_data[14] is enabled by defining FIELD_PACKER_PARITY_EN.
module field_packer (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [2:0]  i_data,
   input  logic [1:0]  i_sel,
   input  logic        i_valid,
   output logic        o_ready,
   output logic [15:0] o_data,
   output logic        o_valid,
   input  logic        i_ready
);

   localparam logic [0:0] S_COLLECT = 1'b0;
   localparam logic [0:0] S_HOLD    = 1'b1;

   logic [0:0]  r_state;
   logic [1:0]  r_cnt;
   logic [13:0] r_data;
   logic [13:0] w_next_data;
   logic        w_accept;
   logic        w_par;

   assign w_accept = i_valid && (r_state == S_COLLECT);

   // Word contents after the current beat is merged in; beat 0 starts a fresh word.
   always_comb begin
      w_next_data = r_data;
      if (r_cnt == 2'd0) begin
         w_next_data[13:5] = 9'd0;
         w_next_data[1:0]  = i_sel;
      end
      case (r_cnt)
         2'd0:    w_next_data[4:2]   = i_data;
         2'd1:    w_next_data[7:5]   = i_data;
         2'd2:    w_next_data[10:8]  = i_data;
         default: w_next_data[13:11] = i_data;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_COLLECT;
         r_cnt   <= 2'd0;
         r_data  <= 14'd0;
      end else begin
         case (r_state)
            S_COLLECT: begin
               if (w_accept) begin
                  r_data <= w_next_data;
                  r_cnt  <= r_cnt + 2'd1;
                  if (r_cnt == 2'd3) r_state <= S_HOLD;
               end
            end
            default: begin
               if (i_ready) r_state <= S_COLLECT;
            end
         endcase
      end
   end

`ifdef FIELD_PACKER_PARITY_EN
   logic r_par;

   // Parity covers the completed word only; any new word starts with it cleared.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_par <= 1'b0;
      end else if (w_accept) begin
         r_par <= (r_cnt == 2'd3) ? ^w_next_data : 1'b0;
      end
   end

   assign w_par = r_par;
`else
   assign w_par = 1'b0;
`endif

   assign o_ready = (r_state == S_COLLECT);
   assign o_valid = (r_state == S_HOLD);
   assign o_data  = {1'b0, w_par, r_data};

endmodule

// File: tb/tb_field_packer.sv
// Self-checking bench for field_packer: directed scenarios plus a randomized run against a word-level model.
// Build with FIELD_PACKER_PARITY_EN defined to check the parity variant.
module tb_field_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  data;
   logic [1:0]  sel;
   logic        valid;
   logic        ready_out;
   logic [15:0] dout;
   logic        vout;
   logic        ready_in;

   int total = 0;
   int bad   = 0;

   field_packer dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_data  (data),
      .i_sel   (sel),
      .i_valid (valid),
      .o_ready (ready_out),
      .o_data  (dout),
      .o_valid (vout),
      .i_ready (ready_in)
   );

   always #5 clk = ~clk;

   // Expected packed word computed from the field placement rule.
   function automatic logic [15:0] exp_word(input int s, input int d0, input int d1,
                                            input int d2, input int d3);
      int v;
      logic [15:0] w;
      v = s + d0 * 4 + d1 * 32 + d2 * 256 + d3 * 2048;
      w = v[15:0];
`ifdef FIELD_PACKER_PARITY_EN
      w[14] = ^w[13:0];
`endif
      return w;
   endfunction

   // One clock: inputs set beforehand are sampled on posedge; outputs read on the following negedge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic beat(input int s, input int d);
      valid = 1'b1;
      sel   = s[1:0];
      data  = d[2:0];
      cyc();
      valid = 1'b0;
   endtask

   task automatic put_word(input int s, input int d0, input int d1, input int d2, input int d3);
      beat(s, d0);
      beat(0, d1);
      beat(0, d2);
      beat(0, d3);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      valid = 1'b0;
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (dout !== 16'h0000 || vout !== 1'b0 || ready_out !== 1'b1) begin
         bad++;
         $display("FAIL reset: data=%h valid=%b ready=%b required data=0000 valid=0 ready=1",
                  dout, vout, ready_out);
      end
      $display("reset: data=%h valid=%b ready=%b", dout, vout, ready_out);
   endtask

   task automatic test_basic();
      logic [15:0] e;
      e = exp_word(2, 5, 2, 7, 1);
      ready_in = 1'b1;
      beat(2, 5);
      beat(1, 2);
      beat(3, 7);
      total++;
      if (vout !== 1'b0) begin
         bad++;
         $display("FAIL basic_early_valid: valid=%b required 0", vout);
      end
      beat(0, 1);
      total++;
      if (vout !== 1'b1 || dout !== e || e !== 16'h0F56) begin
         bad++;
         $display("FAIL basic_word: valid=%b data=%h required valid=1 data=0F56", vout, dout);
      end
      cyc();
      total++;
      if (vout !== 1'b0 || ready_out !== 1'b1) begin
         bad++;
         $display("FAIL basic_one_cycle: valid=%b ready=%b required valid=0 ready=1", vout, ready_out);
      end
      $display("basic: word=%h", e);
   endtask

   task automatic test_backpressure();
      logic [15:0] e;
      e = exp_word(0, 1, 1, 1, 1);
      ready_in = 1'b0;
      put_word(0, 1, 1, 1, 1);
      valid = 1'b1;
      sel   = 2'd3;
      data  = 3'd7;
      for (int i = 0; i < 6; i++) begin
         total++;
         if (vout !== 1'b1 || ready_out !== 1'b0 || dout !== e) begin
            bad++;
            $display("FAIL backpressure_hold%0d: valid=%b ready=%b data=%h required 1 0 %h",
                     i, vout, ready_out, dout, e);
         end
         cyc();
      end
      ready_in = 1'b1;
      cyc();
      total++;
      if (vout !== 1'b0 || ready_out !== 1'b1 || dout !== e) begin
         bad++;
         $display("FAIL backpressure_exit: valid=%b ready=%b data=%h required 0 1 %h",
                  vout, ready_out, dout, e);
      end
      // The beat held on i_valid across the exit is accepted only now, as beat 0.
      cyc();
      valid = 1'b0;
      total++;
      if (dout[13:0] !== 14'h001F) begin
         bad++;
         $display("FAIL backpressure_next_beat0: data=%h required low bits 001F", dout);
      end
      put_word(0, 0, 0, 0, 0);
      cyc();
      $display("backpressure: word=%h", e);
   endtask

   task automatic test_parity();
      logic [15:0] e;
      ready_in = 1'b1;
      put_word(0, 1, 0, 0, 0);
`ifdef FIELD_PACKER_PARITY_EN
      e = 16'h4004;
`else
      e = 16'h0004;
`endif
      total++;
      if (vout !== 1'b1 || dout !== e) begin
         bad++;
         $display("FAIL parity_word: valid=%b data=%h required valid=1 data=%h", vout, dout, e);
      end
      cyc();
      $display("parity: word=%h", dout);
   endtask

   task automatic test_stall();
      ready_in = 1'b1;
      beat(2, 5);
      beat(0, 2);
      for (int i = 0; i < 3; i++) begin
         sel  = 2'($urandom);
         data = 3'($urandom);
         cyc();
      end
      total++;
      if (dout[13:0] !== 14'h0056 || vout !== 1'b0 || ready_out !== 1'b1) begin
         bad++;
         $display("FAIL stall_partial: data=%h valid=%b ready=%b required 0056 0 1", dout, vout, ready_out);
      end
      beat(1, 7);
      beat(3, 1);
      total++;
      if (vout !== 1'b1 || dout !== 16'h0F56) begin
         bad++;
         $display("FAIL stall_word: valid=%b data=%h required 1 0F56", vout, dout);
      end
      cyc();
      $display("stall: word=%h", dout);
   endtask

   task automatic test_reset_mid();
      ready_in = 1'b1;
      beat(0, 3);
      beat(0, 3);
      rst = 1'b1;
      valid = 1'b1;
      data  = 3'd6;
      cyc();
      rst = 1'b0;
      valid = 1'b0;
      total++;
      if (dout !== 16'h0000 || vout !== 1'b0 || ready_out !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid: data=%h valid=%b ready=%b required 0000 0 1", dout, vout, ready_out);
      end
      put_word(2, 5, 2, 7, 1);
      total++;
      if (vout !== 1'b1 || dout !== 16'h0F56) begin
         bad++;
         $display("FAIL reset_mid_word: valid=%b data=%h required 1 0F56", vout, dout);
      end
      // Reset while holding a word discards it.
      ready_in = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      total++;
      if (vout !== 1'b0 || dout !== 16'h0000) begin
         bad++;
         $display("FAIL reset_in_hold: valid=%b data=%h required 0 0000", vout, dout);
      end
      ready_in = 1'b1;
      $display("reset_mid: data=%h", dout);
   endtask

   task automatic test_back_to_back();
      int d[8];
      int idx;
      logic [15:0] e1, e2;
      d = '{7, 7, 7, 7, 0, 0, 0, 0};
      e1 = exp_word(3, 7, 7, 7, 7);
      e2 = exp_word(1, 0, 0, 0, 0);
      ready_in = 1'b1;
      valid = 1'b1;
      idx = 0;
      for (int t = 0; t < 9; t++) begin
         data = d[idx][2:0];
         sel  = (idx == 0) ? 2'd3 : 2'd1;
         cyc();
         if (t != 4) idx++;
         if (t == 3 || t == 8) begin
            total++;
            if (vout !== 1'b1 || dout !== ((t == 3) ? e1 : e2)) begin
               bad++;
               $display("FAIL b2b_word_t%0d: valid=%b data=%h required 1 %h",
                        t, vout, dout, (t == 3) ? e1 : e2);
            end
         end else begin
            total++;
            if (vout !== 1'b0) begin
               bad++;
               $display("FAIL b2b_valid_t%0d: valid=%b required 0", t, vout);
            end
         end
      end
      valid = 1'b0;
      cyc();
      $display("back_to_back: words=%h %h", e1, e2);
   endtask

   task automatic test_random();
      int n;
      int f[4];
      int s;
      logic [15:0] e;
      int words;
      do_reset();
      n = 0;
      words = 0;
      e = 16'h0;
      s = 0;
      for (int t = 0; t < 600; t++) begin
         valid    = 1'($urandom);
         ready_in = ($urandom_range(0, 3) != 0);
         data     = 3'($urandom);
         sel      = 2'($urandom);
         total++;
         if (ready_out !== (n < 4) || vout !== (n == 4) || (n == 4 && dout !== e)) begin
            bad++;
            $display("FAIL random_t%0d: ready=%b valid=%b data=%h required ready=%b valid=%b data=%h",
                     t, ready_out, vout, dout, n < 4, n == 4, e);
         end
         if (n == 4) begin
            if (ready_in) begin
               n = 0;
               words++;
            end
         end else if (valid) begin
            if (n == 0) s = int'(sel);
            f[n] = int'(data);
            n++;
            if (n == 4) e = exp_word(s, f[0], f[1], f[2], f[3]);
         end
         cyc();
      end
      valid = 1'b0;
      $display("random: words=%0d", words);
   endtask

   initial begin
      rst = 1'b1;
      data = '0;
      sel = '0;
      valid = 1'b0;
      ready_in = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_backpressure();
      test_parity();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
